// File: rtl/lut_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational lookup table.
// Ports: clk/reset, br_* and ld_* request/ack/data, lut_key/lut_addr to the table, key_err.
module lut_arbiter #(
  parameter int unsigned MAX_KEY = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       br_req,
  input  logic [7:0] br_key,
  output logic       br_ack,
  output logic [7:0] br_data,
  input  logic       ld_req,
  input  logic [7:0] ld_key,
  output logic       ld_ack,
  output logic [7:0] ld_data,
  output logic [7:0] lut_key,
  input  logic [7:0] lut_addr,
  output logic       key_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACK_BR,
    ACK_LD
  } state_t;

  state_t state;
  logic   last_ld;
  logic   br_elig;
  logic   ld_elig;
  logic   win_br;
  logic   win_ld;
  logic   bad_key;

  // A requester is masked in its own ack cycle so a still-high
  // req is not served twice.
  always_comb begin
    br_elig = br_req && (state != ACK_BR);
    ld_elig = ld_req && (state != ACK_LD);
    win_br  = !reset && br_elig && (!ld_elig || last_ld);
    win_ld  = !reset && ld_elig && (!br_elig || !last_ld);
    lut_key = 8'h00;
    unique case (1'b1)
      win_br:  lut_key = br_key;
      win_ld:  lut_key = ld_key;
      default: lut_key = 8'h00;
    endcase
    bad_key = (32'(lut_key) > MAX_KEY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      last_ld <= 1'b1;
      br_ack  <= 1'b0;
      ld_ack  <= 1'b0;
      br_data <= 8'h00;
      ld_data <= 8'h00;
      key_err <= 1'b0;
    end else begin
      key_err <= (win_br || win_ld) && bad_key;
      if (win_br) begin
        state   <= ACK_BR;
        br_ack  <= 1'b1;
        ld_ack  <= 1'b0;
        br_data <= lut_addr;
        last_ld <= 1'b0;
      end else if (win_ld) begin
        state   <= ACK_LD;
        br_ack  <= 1'b0;
        ld_ack  <= 1'b1;
        ld_data <= lut_addr;
        last_ld <= 1'b1;
      end else begin
        state   <= IDLE;
        br_ack  <= 1'b0;
        ld_ack  <= 1'b0;
      end
    end
  end

endmodule
